// File: rtl/sipo_vector_buffer.sv
// sipo_vector_buffer
//   Multi-lane serial-in/parallel-out vector buffer. Accepts LANES elements per
//   input beat and assembles a DEPTH-element vector, presented in parallel with
//   a valid/ready handshake. An early s_last pads the remainder of the vector
//   with zeros. m_count reports how many elements are real data.
//
//   Optional build macro: SIPO_VECTOR_OVERLAP_EN
//     defined   : while the vector is held, s_ready follows m_ready so a drain and
//                 the first beat of the next frame can share a clock edge.
//     undefined : s_ready is 0 while the vector is held (one idle input cycle
//                 follows every drain).
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   s_data           LANES*WIDTH input beat, lane 0 = earliest element
//   s_valid/s_ready  input handshake
//   s_last           final beat of the frame (qualified by s_valid)
//   m_data           DEPTH*WIDTH vector, element i at [i*WIDTH +: WIDTH]
//   m_valid/m_ready  output handshake
//   m_count          number of real (non-pad) elements in m_data
module sipo_vector_buffer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 64,
  parameter int LANES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES*WIDTH-1:0]       s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [DEPTH*WIDTH-1:0]       m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   m_count
);

  localparam int BEATS = DEPTH / LANES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = DEPTH * WIDTH;
  localparam int LW    = LANES * WIDTH;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] LANES_C   = CW'(LANES);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_FULL
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]   beat_q,  beat_d;
  logic [CW-1:0]   elem_q,  elem_d;
  logic            s_ready_c;

  // Register shifted down by one beat, with either the input beat or zeros
  // entering at the top. When a single beat fills the vector there is nothing
  // left to shift, so the new contents are just the beat itself.
  logic [DW-1:0]   shift_in;
  logic [DW-1:0]   shift_zero;

  generate
    if (DEPTH == LANES) begin : g_single_beat
      assign shift_in   = s_data;
      assign shift_zero = '0;
    end else begin : g_multi_beat
      assign shift_in   = {s_data, shreg_q[DW-1:LW]};
      assign shift_zero = {{LW{1'b0}}, shreg_q[DW-1:LW]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    beat_d    = beat_q;
    elem_d    = elem_q;
    s_ready_c = 1'b0;

    case (state_q)
      ST_FILL: begin
        s_ready_c = 1'b1;
        if (s_valid) begin
          shreg_d = shift_in;
          beat_d  = beat_q + 1'b1;
          elem_d  = elem_q + LANES_C;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_FULL;
          end else if (s_last) begin
            state_d = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        shreg_d = shift_zero;
        beat_d  = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = ST_FULL;
        end
      end

      ST_FULL: begin
`ifdef SIPO_VECTOR_OVERLAP_EN
        s_ready_c = m_ready;
`endif
        if (m_ready) begin
          state_d = ST_FILL;
          beat_d  = '0;
          elem_d  = '0;
`ifdef SIPO_VECTOR_OVERLAP_EN
          // Drain and first beat of the next frame on the same edge: apply the
          // FILL rules as if the beat counter had already been cleared.
          if (s_valid) begin
            shreg_d = shift_in;
            beat_d  = BW'(1);
            elem_d  = LANES_C;
            if (LAST_BEAT == '0) begin
              state_d = ST_FULL;
            end else if (s_last) begin
              state_d = ST_PAD;
            end
          end
`endif
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      shreg_q <= '0;
      beat_q  <= '0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
      elem_q  <= elem_d;
    end
  end

  assign s_ready = s_ready_c && !rst;
  assign m_valid = (state_q == ST_FULL);
  assign m_data  = shreg_q;
  assign m_count = elem_q;

endmodule

// File: tb/tb_sipo_vector_buffer.sv
module tb_sipo_vector_buffer;

  localparam int WIDTH = 10;
  localparam int DEPTH = 8;
  localparam int LANES = 2;
  localparam int BEATS = DEPTH / LANES;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = DEPTH * WIDTH;

`ifdef SIPO_VECTOR_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LANES*WIDTH-1:0] s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;
  logic [DW-1:0]          m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [CW-1:0]          m_count;

  sipo_vector_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LANES(LANES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_count(m_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Elements of the current frame in arrival order.
  int elem_q[$];

  // Records every vector handed downstream while enabled.
  bit            mon_en = 1'b0;
  int            mon_cyc[$];
  logic [DW-1:0] mon_data[$];
  always @(negedge clk) begin
    if (mon_en && m_valid === 1'b1 && m_ready === 1'b1) begin
      mon_cyc.push_back(cyc);
      mon_data.push_back(m_data);
    end
  end

  // Reference: element i is the i-th element received, zero beyond the data.
  function automatic logic [DW-1:0] model_vec(input int q[$]);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < q.size()) v[i*WIDTH +: WIDTH] = WIDTH'(q[i]);
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] model_cnt(input int q[$]);
    return CW'((q.size() > DEPTH) ? DEPTH : q.size());
  endfunction

  // Drives nbeats beats starting at a negedge; returns at the negedge after the
  // final beat was accepted. base < 0 selects random element values.
  task automatic push_beats(input int nbeats, input bit last_flag, input int base);
    bit acc;
    int waited;
    int vals[LANES];
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < LANES; j++) begin
        vals[j] = (base >= 0) ? (base + b*LANES + j) : int'($urandom_range(0, 1023));
        s_data[j*WIDTH +: WIDTH] = WIDTH'(vals[j]);
      end
      s_valid = 1'b1;
      s_last  = last_flag && (b == nbeats - 1);
      waited  = 0;
      do begin
        #1;
        acc = (s_ready === 1'b1);
        @(negedge clk);
        waited++;
      end while (!acc && waited < 20);
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL beat_accept: beat %0d not accepted within %0d cycles", b, waited);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      for (int j = 0; j < LANES; j++) elem_q.push_back(vals[j]);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    total++; if (m_count !== '0) begin bad++; $display("FAIL reset_m_count: got %0d want 0", m_count); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    rst = 1'b0;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
    @(negedge clk);
  endtask

  task automatic test_full_frame;
    logic [DW-1:0] exp_v;
    elem_q.delete();
    m_ready = 1'b1;
    push_beats(BEATS, 1'b0, 0);
    exp_v = model_vec(elem_q);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL full_latency: m_valid got %b want 1", m_valid); end
    total++; if (m_data !== exp_v) begin bad++; $display("FAIL full_data: got %h want %h", m_data, exp_v); end
    total++; if (m_count !== CW'(DEPTH)) begin bad++; $display("FAIL full_count: got %0d want %0d", m_count, DEPTH); end
    total++; if (s_ready !== OVL) begin bad++; $display("FAIL full_s_ready: got %b want %b", s_ready, OVL); end
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL full_drain: m_valid got %b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL full_refill: s_ready got %b want 1", s_ready); end
    m_ready = 1'b0;
  endtask

  task automatic test_early_last;
    logic [DW-1:0] exp_v;
    elem_q.delete();
    m_ready = 1'b0;
    push_beats(2, 1'b1, 10);
    for (int p = 0; p < BEATS - 2; p++) begin
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pad_s_ready[%0d]: got %b want 0", p, s_ready); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL pad_m_valid[%0d]: got %b want 0", p, m_valid); end
      @(negedge clk);
    end
    exp_v = model_vec(elem_q);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL pad_done: m_valid got %b want 1", m_valid); end
    total++; if (m_data !== exp_v) begin bad++; $display("FAIL pad_data: got %h want %h", m_data, exp_v); end
    total++; if (m_count !== CW'(4)) begin bad++; $display("FAIL pad_count: got %0d want 4", m_count); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL pad_drain: m_valid got %b want 0", m_valid); end
  endtask

  task automatic test_hold;
    logic [DW-1:0] exp_v;
    elem_q.delete();
    m_ready = 1'b0;
    push_beats(BEATS, 1'b0, -1);
    exp_v = model_vec(elem_q);
    s_data  = LANES*WIDTH'($urandom());
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", k, m_valid); end
      total++; if (m_data !== exp_v) begin bad++; $display("FAIL hold_data[%0d]: got %h want %h", k, m_data, exp_v); end
      total++; if (m_count !== CW'(DEPTH)) begin bad++; $display("FAIL hold_count[%0d]: got %0d want %0d", k, m_count, DEPTH); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL hold_s_ready[%0d]: got %b want 0", k, s_ready); end
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL hold_drain: m_valid got %b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL hold_fill: s_ready got %b want 1", s_ready); end
    total++; if (m_count !== '0) begin bad++; $display("FAIL hold_count_clear: got %0d want 0", m_count); end
  endtask

  task automatic test_reset_abort;
    logic [DW-1:0] exp_v;
    elem_q.delete();
    m_ready = 1'b0;
    push_beats(2, 1'b1, 10);
    rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL abort_m_valid: got %b want 0", m_valid); end
    total++; if (m_count !== '0) begin bad++; $display("FAIL abort_m_count: got %0d want 0", m_count); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_s_ready: got %b want 0", s_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL abort_release: s_ready got %b want 1", s_ready); end
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL abort_no_vector: m_valid got %b want 0", m_valid); end
    elem_q.delete();
    push_beats(BEATS, 1'b0, -1);
    exp_v = model_vec(elem_q);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL abort_next_valid: got %b want 1", m_valid); end
    total++; if (m_data !== exp_v) begin bad++; $display("FAIL abort_next_data: got %h want %h", m_data, exp_v); end
    total++; if (m_count !== CW'(DEPTH)) begin bad++; $display("FAIL abort_next_count: got %0d want %0d", m_count, DEPTH); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_last_on_final;
    logic [DW-1:0] exp_v;
    elem_q.delete();
    m_ready = 1'b0;
    push_beats(BEATS, 1'b1, -1);
    exp_v = model_vec(elem_q);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL lastfinal_valid: got %b want 1", m_valid); end
    total++; if (m_data !== exp_v) begin bad++; $display("FAIL lastfinal_data: got %h want %h", m_data, exp_v); end
    total++; if (m_count !== CW'(DEPTH)) begin bad++; $display("FAIL lastfinal_count: got %0d want %0d", m_count, DEPTH); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int q1[$];
    int q2[$];
    int want_gap;
    want_gap = OVL ? BEATS : BEATS + 1;
    elem_q.delete();
    mon_cyc.delete();
    mon_data.delete();
    m_ready = 1'b1;
    mon_en  = 1'b1;
    push_beats(2*BEATS, 1'b0, -1);
    @(negedge clk);
    mon_en  = 1'b0;
    m_ready = 1'b0;
    q1 = elem_q[0:DEPTH-1];
    q2 = elem_q[DEPTH:2*DEPTH-1];
    total++; if (mon_cyc.size() !== 2) begin bad++; $display("FAIL b2b_vectors: got %0d want 2", mon_cyc.size()); end
    if (mon_cyc.size() == 2) begin
      total++; if (mon_cyc[1] - mon_cyc[0] !== want_gap) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", mon_cyc[1] - mon_cyc[0], want_gap); end
      total++; if (mon_data[0] !== model_vec(q1)) begin bad++; $display("FAIL b2b_data0: got %h want %h", mon_data[0], model_vec(q1)); end
      total++; if (mon_data[1] !== model_vec(q2)) begin bad++; $display("FAIL b2b_data1: got %h want %h", mon_data[1], model_vec(q2)); end
    end
  endtask

  task automatic test_random_frames;
    int nb;
    bit lst;
    int n;
    int stall;
    logic [DW-1:0] exp_v;
    logic [CW-1:0] exp_c;
    for (int f = 0; f < 8; f++) begin
      nb  = int'($urandom_range(1, BEATS));
      lst = (nb < BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
      m_ready = 1'b0;
      elem_q.delete();
      push_beats(nb, lst, -1);
      n = 0;
      while (m_valid !== 1'b1 && n < 10) begin
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rnd_pad_ready[%0d]: got %b want 0", f, s_ready); end
        @(negedge clk);
        n++;
      end
      exp_v = model_vec(elem_q);
      exp_c = model_cnt(elem_q);
      total++; if (n !== BEATS - nb) begin bad++; $display("FAIL rnd_pad_cycles[%0d]: got %0d want %0d", f, n, BEATS - nb); end
      total++; if (m_data !== exp_v) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", f, m_data, exp_v); end
      total++; if (m_count !== exp_c) begin bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", f, m_count, exp_c); end
      stall = int'($urandom_range(0, 3));
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        total++; if (m_valid !== 1'b1 || m_data !== exp_v) begin bad++; $display("FAIL rnd_hold[%0d]: valid %b data %h want 1 %h", f, m_valid, m_data, exp_v); end
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain[%0d]: got %b want 0", f, m_valid); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_early_last();
    test_hold();
    test_reset_abort();
    test_last_on_final();
    test_back_to_back();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sipo_vector_buffer.md
Name: sipo_vector_buffer

Overview:
- Multi-lane serial-in/parallel-out vector buffer with valid/ready handshakes on both sides.
- Collects LANES elements per accepted beat into a DEPTH-element vector.
- Presents the full vector in parallel to the downstream vector datapath.
- Supports early frame termination with zero padding, and reports the count of real elements.

Parameters:
- WIDTH, 10, bits per element.
- DEPTH, 64, elements per output vector; must be a multiple of LANES.
- LANES, 1, elements accepted per input beat; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- s_data  in  LANES*WIDTH  input beat; lane j occupies bits [j*WIDTH +: WIDTH]; lane 0 is the earliest element.
- s_valid  in  1  input beat valid.
- s_last  in  1  final beat of the frame; qualified by s_valid.
- s_ready  out  1  buffer accepts a beat.
- m_data  out  DEPTH*WIDTH  parallel vector; element i occupies bits [i*WIDTH +: WIDTH].
- m_valid  out  1  vector complete and held.
- m_ready  in  1  downstream takes the vector.
- m_count  out  $clog2(DEPTH+1)  number of real (non-pad) elements in m_data.

Behaviour:
- Reset (async assert, sync release):
  - shift register = 0, state = FILL, beat counter = 0, element count = 0.
  - m_valid = 0, m_count = 0.
  - s_ready is forced 0 while rst is high.
- Shift rule:
  - Accepting a beat shifts the register down by LANES elements: new reg = {s_data, reg[DEPTH-1:LANES]}.
  - After DEPTH/LANES beats, beat k lane j sits at element k*LANES+j, so element 0 is the first element received.
- FILL state:
  - s_ready = 1; a beat is accepted when s_valid && s_ready.
  - Each accepted beat increments the beat counter by 1 and the element count by LANES.
  - Accepted beat is the (DEPTH/LANES)th → FULL, regardless of s_last.
  - Accepted beat has s_last = 1 and is earlier than the (DEPTH/LANES)th → PAD.
- PAD state:
  - s_ready = 0.
  - Each cycle shifts LANES zero elements in at the top and increments the beat counter; the element count is frozen.
  - When the beat counter reaches DEPTH/LANES → FULL.
  - Result: real data occupies elements 0..m_count-1; all higher elements are 0.
  - PAD lasts (DEPTH/LANES − beats received) cycles.
- FULL state:
  - m_valid = 1 and s_ready = 0.
  - m_data and m_count are held stable until m_valid && m_ready.
  - On that handshake → FILL: beat counter and element count clear; register contents are don't-care, since they are overwritten before the next m_valid.
- Latency:
  - m_valid rises the cycle after the clock edge that accepts the final beat.
  - With early s_last, m_valid rises after the PAD cycles complete.
- Element count saturates at DEPTH; no wrap-around is possible.
- s_last on a non-accepted cycle is ignored.
- m_count = DEPTH whenever a frame is completed without early s_last.
- Reset asserted mid-FILL or mid-PAD aborts the frame: the partial vector is discarded and no m_valid is produced.
- m_ready while m_valid = 0 has no effect.

Optional Feature:
- Macro: SIPO_VECTOR_OVERLAP_EN.
- Defined:
  - In FULL, s_ready = m_ready.
  - A simultaneous drain handshake and input beat is legal: the vector is consumed and the beat is accepted as beat 0 of the next frame in the same edge.
  - Next state is FILL with element count = LANES, or directly FULL/PAD per the FILL rules when DEPTH == LANES or s_last is set.
  - Gives back-to-back vectors with no bubble.
- Undefined:
  - s_ready = 0 throughout FULL.
  - Exactly one idle input cycle follows every drain.

Test Plan:
All scenarios use WIDTH=10, DEPTH=8, LANES=2.
1. Four beats with lanes (0,1),(2,3),(4,5),(6,7), m_ready=1 → m_valid one cycle after beat 4; m_data[i]=i for i=0..7; m_count=8; s_ready=0 during FULL.
2. Beats (10,11),(12,13) with s_last on beat 2 → two PAD cycles with s_ready=0, then m_valid; m_data = {10,11,12,13,0,0,0,0} in element order; m_count=4.
3. Full frame with m_ready=0 for 5 cycles after m_valid → m_valid, m_data and m_count stable for all 5 cycles; s_valid held high is never accepted; drain on cycle 6 → FILL.
4. Assert rst during the first PAD cycle of scenario 2 → m_valid=0, m_count=0, s_ready=0 while rst is high and 1 after release; the next full frame yields a correct vector with no residue from the aborted frame.
5. s_last on beat 4 of a full frame → no PAD; m_valid in the next cycle; m_count=8.
6. Continuous s_valid across two frames with m_ready=1 → with SIPO_VECTOR_OVERLAP_EN, the second vector's m_valid follows the first by exactly 4 cycles; without it, by exactly 5 cycles.
